// File: rtl/lfsr9_checker.sv
// ---------------------------------------------------------------------------
// lfsr9_checker
//
// Receive-side checker for the 9-bit XNOR LFSR stream (taps 4 and 8). It fills
// a local shift register from the incoming bits, confirms that a run of
// VERIFY_LEN bits follows the predicted sequence, and then free-runs
// ("flywheels") on its own prediction. Every mismatch seen while locked is
// flagged and counted. LOSS_THRESH consecutive mismatches drop the lock, and
// the checker then re-acquires on its own.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous, active-low reset
//   bit_in     : received stream bit (the generator's new feedback bit)
//   bit_valid  : qualifies bit_in; state advances only when high
//   clear      : synchronous clear of err_count (wins over an increment)
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse per counted mismatch
//   err_count  : saturating count of mismatches seen while locked
//   state      : debug, 0 SEEK / 1 VERIFY / 2 LOCKED
// ---------------------------------------------------------------------------
module lfsr9_checker #(
    parameter int unsigned VERIFY_LEN  = 4,
    parameter int unsigned LOSS_THRESH = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int unsigned VER_W  = $clog2(VERIFY_LEN + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);

    // Last value the counters hold before the transition fires.
    localparam logic [VER_W-1:0]  VER_LAST  = VER_W'(VERIFY_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

    state_e              state_q, state_d;
    logic [8:0]          sr_q, sr_d;
    logic [3:0]          fill_q, fill_d;
    logic [VER_W-1:0]    ver_q, ver_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                pulse_q, pulse_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pred;
    logic                match;
    logic [8:0]          sr_rx;

    assign pred  = ~(sr_q[4] ^ sr_q[8]);
    assign match = (bit_in == pred);
    assign sr_rx = {sr_q[7:0], bit_in};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        ver_d   = ver_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;

        if (bit_valid) begin
            unique case (state_q)
                SEEK: begin
                    sr_d = sr_rx;
                    if (fill_q != 4'd9) begin
                        fill_d = fill_q + 4'd1;
                    end
                    // Fill saturates at 9, so an all-ones (XNOR lockup) window
                    // is re-tested on every following valid bit.
                    if ((fill_q >= 4'd8) && (sr_rx != 9'h1FF)) begin
                        state_d = VERIFY;
                        ver_d   = '0;
                    end
                end

                VERIFY: begin
                    sr_d = sr_rx;
                    if (match) begin
                        ver_d = ver_q + 1'b1;
                        if (ver_q == VER_LAST) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = SEEK;
                        fill_d  = '0;
                        ver_d   = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel: shift the prediction, not the received bit, so
                    // one corrupted bit costs exactly one count.
                    sr_d = {sr_q[7:0], pred};
                    if (!match) begin
                        pulse_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        miss_d = miss_q + 1'b1;
                        if (miss_q == MISS_LAST) begin
                            state_d = SEEK;
                            fill_d  = '0;
                            ver_d   = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end

                default: begin
                    state_d = SEEK;
                    fill_d  = '0;
                    ver_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end

        if (clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEEK;
            sr_q    <= '0;
            fill_q  <= '0;
            ver_q   <= '0;
            miss_q  <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            ver_q   <= ver_d;
            miss_q  <= miss_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr9_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr9_checker
//
// Bench for lfsr9_checker. A reference 9-bit XNOR generator produces the
// stream. Directed tables and sequences cover acquisition, valid gaps, errors,
// clear, loss of lock, saturation, async reset and lockup rejection. A random
// phase is compared cycle by cycle against a queue-based behavioural model.
// The counter width is reduced to 4 bits so that saturation is reachable.
// ---------------------------------------------------------------------------
module tb_lfsr9_checker;

    localparam int unsigned VLEN = 4;
    localparam int unsigned LTH  = 3;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          bit_in;
    logic          bit_valid;
    logic          clear;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [1:0]    state;

    lfsr9_checker #(
        .VERIFY_LEN (VLEN),
        .LOSS_THRESH(LTH),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .clear    (clear),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .state    (state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference generator: starts at 0, emits xnor(g[4], g[8]) each step.
    logic [8:0] gsr;

    task automatic gen_step(output bit b);
        b   = ~(gsr[4] ^ gsr[8]);
        gsr = {gsr[7:0], b};
    endtask

    // Drive one clock's worth of inputs, sample 1 ns after the edge.
    task automatic cycle(input bit v, input bit b, input bit c);
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bit_valid = 1'b0;
        clear     = 1'b0;
        bit_in    = 1'b0;
        reset     = 1'b0;
        #3;
        reset     = 1'b1;
        gsr       = '0;
    endtask

    // ---------------- behavioural model ----------------
    // History window: mq[0] is the oldest of the last nine bits, mq[8] newest.
    bit mq[$];
    int m_mode, m_fill, m_good, m_miss, m_cnt;
    bit m_pulse;

    task automatic model_reset();
        mq.delete();
        repeat (9) mq.push_back(1'b0);
        m_mode  = 0;
        m_fill  = 0;
        m_good  = 0;
        m_miss  = 0;
        m_cnt   = 0;
        m_pulse = 0;
    endtask

    task automatic model_push(input bit x);
        mq.push_back(x);
        void'(mq.pop_front());
    endtask

    function automatic bit model_all_ones();
        int ones = 0;
        foreach (mq[i]) ones += int'(mq[i]);
        return ones == 9;
    endfunction

    task automatic model_step(input bit v, input bit b, input bit c);
        bit pred;
        m_pulse = 0;
        if (v) begin
            pred = !(mq[4] ^ mq[0]);
            if (m_mode == 0) begin
                model_push(b);
                if (m_fill < 9) m_fill++;
                if (m_fill == 9 && !model_all_ones()) begin
                    m_mode = 1;
                    m_good = 0;
                end
            end else if (m_mode == 1) begin
                model_push(b);
                if (b == pred) begin
                    m_good++;
                    if (m_good == VLEN) begin
                        m_mode = 2;
                        m_miss = 0;
                    end
                end else begin
                    m_mode = 0;
                    m_fill = 0;
                    m_good = 0;
                end
            end else begin
                model_push(pred);
                if (b != pred) begin
                    m_pulse = 1;
                    if (m_cnt < CMAX) m_cnt++;
                    m_miss++;
                    if (m_miss == LTH) begin
                        m_mode = 0;
                        m_fill = 0;
                        m_good = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) m_cnt = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit valid;
        bit flip;
        bit clr;
        bit e_locked;
        bit e_pulse;
        int e_cnt;
        int e_state;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t e;
        bit   g;
        bit   fl;
        int   cnt_e;
        int   n;
        bit   b;
        int   rate;

        reset     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        clear     = 1'b0;
        gsr       = '0;
        #12;
        chk("rst_state",  int'(state), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_pulse",  int'(err_pulse), 0);
        chk("rst_cnt",    int'(err_count), 0);
        reset = 1'b1;

        // Valid bits alternate with gap cycles. Errors on valid bits 16, 18,
        // 20, 21; clear alone in the gap after bit 19, clear with error on 21.
        cnt_e = 0;
        for (int k = 1; k <= 23; k++) begin
            fl         = (k == 16) || (k == 18) || (k == 20) || (k == 21);
            e.valid    = 1'b1;
            e.flip     = fl;
            e.clr      = (k == 21);
            e.e_state  = (k < 9) ? 0 : ((k < 13) ? 1 : 2);
            e.e_locked = (k >= 13);
            e.e_pulse  = fl;
            if (fl) cnt_e++;
            if (k == 21) cnt_e = 0;
            e.e_cnt    = cnt_e;
            tbl.push_back(e);

            e.valid    = 1'b0;
            e.flip     = 1'b0;
            e.clr      = (k == 19);
            e.e_pulse  = 1'b0;
            if (k == 19) cnt_e = 0;
            e.e_cnt    = cnt_e;
            tbl.push_back(e);
        end

        foreach (tbl[i]) begin
            if (tbl[i].valid) begin
                gen_step(g);
                b = g ^ tbl[i].flip;
            end else begin
                b = bit'($urandom % 2);
            end
            cycle(tbl[i].valid, b, tbl[i].clr);
            chk($sformatf("tbl%0d_state", i),  int'(state),     tbl[i].e_state);
            chk($sformatf("tbl%0d_locked", i), int'(locked),    int'(tbl[i].e_locked));
            chk($sformatf("tbl%0d_pulse", i),  int'(err_pulse), int'(tbl[i].e_pulse));
            chk($sformatf("tbl%0d_cnt", i),    int'(err_count), tbl[i].e_cnt);
        end

        // Loss of lock: three consecutive inverted bits.
        for (int i = 1; i <= 3; i++) begin
            gen_step(g);
            cycle(1'b1, ~g, 1'b0);
            chk($sformatf("loss%0d_pulse", i),  int'(err_pulse), 1);
            chk($sformatf("loss%0d_cnt", i),    int'(err_count), i);
            chk($sformatf("loss%0d_locked", i), int'(locked),    (i < 3) ? 1 : 0);
        end
        chk("loss_state", int'(state), 0);
        for (int i = 1; i <= 13; i++) begin
            gen_step(g);
            cycle(1'b1, g, 1'b0);
            if (i == 9)  chk("reacq9_state", int'(state), 1);
            if (i == 12) chk("reacq12_locked", int'(locked), 0);
        end
        chk("reacq13_locked", int'(locked), 1);
        chk("reacq13_cnt",    int'(err_count), 3);

        // Saturation: isolated errors never drop lock, count stops at max.
        for (int i = 1; i <= 14; i++) begin
            gen_step(g);
            cycle(1'b1, ~g, 1'b0);
            chk($sformatf("sat%0d_pulse", i),  int'(err_pulse), 1);
            chk($sformatf("sat%0d_cnt", i),    int'(err_count), (3 + i > CMAX) ? CMAX : 3 + i);
            chk($sformatf("sat%0d_locked", i), int'(locked),    1);
            gen_step(g);
            cycle(1'b1, g, 1'b0);
            chk($sformatf("sat%0d_clean_pulse", i), int'(err_pulse), 0);
        end
        cycle(1'b0, 1'b0, 1'b1);
        chk("clr_cnt",    int'(err_count), 0);
        chk("clr_locked", int'(locked), 1);

        // Async reset between edges, with pulse and count non-zero.
        gen_step(g);
        cycle(1'b1, ~g, 1'b0);
        chk("pre_rst_pulse", int'(err_pulse), 1);
        chk("pre_rst_cnt",   int'(err_count), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_state",  int'(state), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_pulse",  int'(err_pulse), 0);
        chk("arst_cnt",    int'(err_count), 0);
        #4;
        reset = 1'b1;
        gsr   = '0;
        for (int i = 1; i <= 13; i++) begin
            gen_step(g);
            cycle(1'b1, g, 1'b0);
            if (i == 12) chk("arst_acq12_locked", int'(locked), 0);
        end
        chk("arst_acq13_locked", int'(locked), 1);

        // Long clean run: no errors, lock held.
        for (int i = 0; i < 600; i++) begin
            gen_step(g);
            cycle(1'b1, g, 1'b0);
            chk($sformatf("clean%0d_cnt", i),    int'(err_count), 0);
            chk($sformatf("clean%0d_locked", i), int'(locked), 1);
        end

        // Lockup rejection: constant ones never leave SEEK.
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            chk($sformatf("lockup%0d_state", i),  int'(state), 0);
            chk($sformatf("lockup%0d_locked", i), int'(locked), 0);
        end
        gsr = '0;
        n   = 0;
        while (!locked && n < 200) begin
            gen_step(g);
            cycle(1'b1, g, 1'b0);
            n++;
        end
        chk("lockup_relock", int'(locked), 1);

        // Random stimulus against the behavioural model.
        apply_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit c;
            case ((i / 500) % 3)
                0:       rate = 2;
                1:       rate = 0;
                default: rate = 25;
            endcase
            v = ($urandom % 4) != 0;
            c = ($urandom % 50) == 0;
            if (v) begin
                gen_step(g);
                b = g ^ (($urandom % 100) < rate);
            end else begin
                b = bit'($urandom % 2);
            end
            cycle(v, b, c);
            model_step(v, b, c);
            chk($sformatf("rnd%0d_state", i),  int'(state),     m_mode);
            chk($sformatf("rnd%0d_locked", i), int'(locked),    (m_mode == 2) ? 1 : 0);
            chk($sformatf("rnd%0d_pulse", i),  int'(err_pulse), int'(m_pulse));
            chk($sformatf("rnd%0d_cnt", i),    int'(err_count), m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
